// File: rtl/alu_uart_if.sv
// alu_uart_if: bundles the UART byte stream, ALU operand/result and transmit handshake signals
interface alu_uart_if #(
  parameter int SIZE    = 8,
  parameter int OP_SIZE = 6
);
  logic                rx_done;
  logic [SIZE-1:0]     rx_data;
  logic [SIZE-1:0]     alu_res;
  logic                alu_carry;
  logic                tx_done;
  logic [SIZE-1:0]     a_alu;
  logic [SIZE-1:0]     b_alu;
  logic [OP_SIZE-1:0]  opcode_alu;
  logic [SIZE-1:0]     tx_data;
  logic                tx_start;
  logic                busy;
  logic                op_error;
  logic                overrun;
  modport slave (
    input  rx_done, rx_data, alu_res, alu_carry, tx_done,
    output a_alu, b_alu, opcode_alu, tx_data, tx_start, busy, op_error, overrun
  );
  modport master (
    output rx_done, rx_data, alu_res, alu_carry, tx_done,
    input  a_alu, b_alu, opcode_alu, tx_data, tx_start, busy, op_error, overrun
  );
endinterface

// File: rtl/alu_uart_interface.sv
// alu_uart_interface: collects A/B/opcode bytes from UART, drives the ALU, and transmits the result.
// Optional macro CARRY_TX_EN sends the ALU carry as a second byte after the result.
module alu_uart_interface #(
  parameter int SIZE    = 8,
  parameter int OP_SIZE = 6
) (
  input logic       clk,
  input logic       rst,
  alu_uart_if.slave bus
);
`ifdef CARRY_TX_EN
  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND_START, SEND_WAIT, SEND2_START, SEND2_WAIT
  } state_t;
  logic carry;
`else
  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND_START, SEND_WAIT
  } state_t;
  logic unused_carry;
  assign unused_carry = bus.alu_carry;
`endif
  state_t state;
  logic [OP_SIZE-1:0] op;
  logic op_ok;
  assign op = bus.rx_data[OP_SIZE-1:0];
  assign op_ok = op inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b100110, 6'b000011, 6'b000010, 6'b100111};
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_A;
      bus.a_alu      <= '0;
      bus.b_alu      <= '0;
      bus.opcode_alu <= '0;
      bus.tx_data    <= '0;
      bus.tx_start   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.op_error   <= 1'b0;
      bus.overrun    <= 1'b0;
`ifdef CARRY_TX_EN
      carry          <= 1'b0;
`endif
    end else begin
      if (bus.rx_done && bus.busy) bus.overrun <= 1'b1;
      case (state)
        WAIT_A: if (bus.rx_done) begin
          bus.a_alu <= bus.rx_data;
          state     <= WAIT_B;
        end
        WAIT_B: if (bus.rx_done) begin
          bus.b_alu <= bus.rx_data;
          state     <= WAIT_OP;
        end
        WAIT_OP: if (bus.rx_done) begin
          if (op_ok) begin
            bus.opcode_alu <= op;
            bus.busy       <= 1'b1;
            state          <= COMPUTE;
          end else begin
            bus.op_error <= 1'b1;
            state        <= WAIT_A;
          end
        end
        COMPUTE: begin
          bus.tx_data  <= bus.alu_res;
          bus.tx_start <= 1'b1;
`ifdef CARRY_TX_EN
          carry        <= bus.alu_carry;
`endif
          state        <= SEND_START;
        end
        SEND_START: begin
          bus.tx_start <= 1'b0;
          state        <= SEND_WAIT;
        end
        SEND_WAIT: if (bus.tx_done) begin
`ifdef CARRY_TX_EN
          bus.tx_data  <= {{(SIZE-1){1'b0}}, carry};
          bus.tx_start <= 1'b1;
          state        <= SEND2_START;
`else
          bus.busy <= 1'b0;
          state    <= WAIT_A;
`endif
        end
`ifdef CARRY_TX_EN
        SEND2_START: begin
          bus.tx_start <= 1'b0;
          state        <= SEND2_WAIT;
        end
        SEND2_WAIT: if (bus.tx_done) begin
          bus.busy <= 1'b0;
          state    <= WAIT_A;
        end
`endif
        default: state <= WAIT_A;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_uart_interface.sv
// tb_alu_uart_interface: scoreboard bench driving UART byte triples through a behavioural ALU
module tb_alu_uart_interface;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_uart_if #(.SIZE(8), .OP_SIZE(6)) bus();
  alu_uart_interface #(.SIZE(8), .OP_SIZE(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  always_comb begin
    bus.alu_res = 8'h00;
    case (bus.opcode_alu)
      6'b100000: bus.alu_res = bus.a_alu + bus.b_alu;
      6'b100010: bus.alu_res = bus.a_alu - bus.b_alu;
      6'b100100: bus.alu_res = bus.a_alu & bus.b_alu;
      6'b100101: bus.alu_res = bus.a_alu | bus.b_alu;
      6'b100110: bus.alu_res = bus.a_alu ^ bus.b_alu;
      6'b000011: bus.alu_res = $signed(bus.a_alu) >>> bus.b_alu;
      6'b000010: bus.alu_res = bus.a_alu >> bus.b_alu;
      6'b100111: bus.alu_res = ~(bus.a_alu | bus.b_alu);
      default:   bus.alu_res = 8'h00;
    endcase
  end
  always @(negedge clk) begin
    if (!rst && bus.tx_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx_start: got data %h, required no start", bus.tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.tx_data !== mon_e) begin
          errors++;
          $display("FAIL tx_data: got %h, required %h", bus.tx_data, mon_e);
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk);
    #1 bus.rx_done = 1'b0;
  endtask
  task automatic tx_pulse();
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
  endtask
  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                     input logic [7:0] res, input logic c, input logic inject);
    bus.alu_carry = c;
    exp_q.push_back(res);
`ifdef CARRY_TX_EN
    exp_q.push_back({7'b0, c});
`endif
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check("busy_compute", bus.busy, 1);
    check("start_early", bus.tx_start, 0);
    @(posedge clk);
    #1 check("start_latency", bus.tx_start, 1);
    @(posedge clk);
    #1 check("start_one_cycle", bus.tx_start, 0);
    if (inject) begin
      send_byte(8'hAA);
      check("overrun_set", bus.overrun, 1);
      check("overrun_tx_data_held", bus.tx_data, res);
      check("overrun_busy", bus.busy, 1);
      check("overrun_a_held", bus.a_alu, a);
    end
    repeat (2) @(posedge clk);
    #1 check("busy_send_wait", bus.busy, 1);
    tx_pulse();
`ifdef CARRY_TX_EN
    check("start2", bus.tx_start, 1);
    check("busy_send2", bus.busy, 1);
    @(posedge clk);
    #1 check("start2_one_cycle", bus.tx_start, 0);
    tx_pulse();
`endif
    check("busy_done", bus.busy, 0);
    check("a_alu", bus.a_alu, a);
    check("b_alu", bus.b_alu, b);
    check("opcode_alu", bus.opcode_alu, {2'b00, op[5:0]});
  endtask
  initial begin
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.tx_done = 1'b0;
    bus.alu_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_a", bus.a_alu, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_op_error", bus.op_error, 0);
    tx_pulse();
    check("stray_tx_done_busy", bus.busy, 0);
    txn(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 1'b0);
    txn(8'h03, 8'h05, 8'h22, 8'hFE, 1'b1, 1'b0);
    txn(8'hF0, 8'h0F, 8'h27, 8'h00, 1'b0, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h3F);
    repeat (4) @(posedge clk);
    #1 check("op_error_set", bus.op_error, 1);
    check("op_error_opcode_kept", bus.opcode_alu, 8'h27);
    check("op_error_busy", bus.busy, 0);
    txn(8'h01, 8'h01, 8'h24, 8'h01, 1'b0, 1'b0);
    check("op_error_sticky", bus.op_error, 1);
    txn(8'h09, 8'h04, 8'h26, 8'h0D, 1'b0, 1'b1);
    txn(8'hF0, 8'h04, 8'h03, 8'hFF, 1'b0, 1'b0);
    txn(8'h80, 8'h03, 8'h02, 8'h10, 1'b0, 1'b0);
    txn(8'hA0, 8'h05, 8'hE5, 8'hA5, 1'b0, 1'b0);
    check("overrun_sticky", bus.overrun, 1);
    send_byte(8'h05);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_a", bus.a_alu, 0);
    check("mid_rst_b", bus.b_alu, 0);
    check("mid_rst_opcode", bus.opcode_alu, 0);
    check("mid_rst_tx_data", bus.tx_data, 0);
    check("mid_rst_op_error", bus.op_error, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    txn(8'h02, 8'h02, 8'h20, 8'h04, 1'b0, 1'b0);
    txn(8'h7F, 8'h01, 8'h20, 8'h80, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
